// File: rtl/sample_pkg.sv
// Shared definitions for the sampled audio path sequencer.
// Contents:
//   seq_state_t  - sequencer state encoding
//   SAMPLE_DW    - default sample data width
//   CLK_DIV_10K  - default divider for a 10 kHz sample rate from 50 MHz
package sample_pkg;

  localparam int SAMPLE_DW   = 10;
  localparam int CLK_DIV_10K = 5000;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ADC_WAIT  = 2'd1,
    PROC_WAIT = 2'd2,
    DAC_WAIT  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running sample-rate divider. Counts 0..CLK_DIV-1 and wraps without
// any gating. tick is high for the single cycle in which the count is at
// CLK_DIV-1, so the first tick shows up CLK_DIV cycles after reset release.
// Ports:
//   sysclk - system clock
//   rst_n  - asynchronous active-low reset
//   tick   - one-cycle sample-rate strobe
module sample_tick_gen
  import sample_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_10K
) (
  input  logic sysclk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = (count_q == LAST) ? '0 : count_q + CW'(1);
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign tick = (count_q == LAST);

endmodule

// File: rtl/sample_sequencer.sv
// Sequencer for the ADC -> processor -> DAC sample path.
// Starts an ADC conversion on each enabled sample tick, captures the ADC word
// into proc_in, waits PROC_LAT cycles for the processor result, then loads it
// into dac_data with a dac_start pulse. A tick that arrives while a sample is
// still in flight is dropped and sets the sticky overrun flag.
// Optional build macro SEQ_OVERRUN_CNT_EN adds overrun_cnt, a saturating
// count of dropped ticks.
// Ports:
//   sysclk, rst_n         - clock, asynchronous active-low reset
//   en                    - gates starting a new sample
//   adc_start/adc_done    - ADC handshake, adc_data valid with adc_done
//   proc_in/proc_out      - processor datapath in/out
//   dac_start/dac_data    - DAC load strobe and held DAC word
//   dac_done              - DAC transfer complete
//   busy                  - sample in flight
//   overrun/overrun_clr   - sticky dropped-tick flag and its clear
//   overrun_cnt           - dropped tick count (SEQ_OVERRUN_CNT_EN only)
//
// state     | meaning
// ----------+------------------------------------------------
// IDLE      | waiting for an enabled tick
// ADC_WAIT  | conversion started, waiting for adc_done
// PROC_WAIT | sample in processor, latency counter running
// DAC_WAIT  | DAC loaded, waiting for dac_done
module sample_sequencer
  import sample_pkg::*;
#(
  parameter int CLK_DIV  = CLK_DIV_10K,
  parameter int PROC_LAT = 1,
  parameter int DW       = SAMPLE_DW
) (
  input  logic          sysclk,
  input  logic          rst_n,
  input  logic          en,
  output logic          adc_start,
  input  logic          adc_done,
  input  logic [DW-1:0] adc_data,
  output logic [DW-1:0] proc_in,
  input  logic [DW-1:0] proc_out,
  output logic          dac_start,
  output logic [DW-1:0] dac_data,
  input  logic          dac_done,
  output logic          busy,
  output logic          overrun,
  input  logic          overrun_clr
`ifdef SEQ_OVERRUN_CNT_EN
  ,
  output logic [7:0]    overrun_cnt
`endif
);

  logic          tick;
  logic          drop;
  seq_state_t    state_q, state_d;
  logic [3:0]    lat_q, lat_d;
  logic          adc_start_q, adc_start_d;
  logic          dac_start_q, dac_start_d;
  logic [DW-1:0] proc_in_q, proc_in_d;
  logic [DW-1:0] dac_data_q, dac_data_d;
  logic          overrun_q, overrun_d;

  sample_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
    .sysclk (sysclk),
    .rst_n  (rst_n),
    .tick   (tick)
  );

  // A tick that cannot start a sample because one is still in flight.
  assign drop = tick && en && (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    adc_start_d = 1'b0;
    dac_start_d = 1'b0;
    proc_in_d   = proc_in_q;
    dac_data_d  = dac_data_q;
    case (state_q)
      IDLE: begin
        if (tick && en) begin
          adc_start_d = 1'b1;
          state_d     = ADC_WAIT;
        end
      end
      ADC_WAIT: begin
        if (adc_done) begin
          proc_in_d = adc_data;
          lat_d     = 4'(PROC_LAT);
          state_d   = PROC_WAIT;
        end
      end
      PROC_WAIT: begin
        // Load when the counter is about to reach zero so dac_start lands
        // exactly PROC_LAT+1 cycles after adc_done.
        if (lat_q <= 4'd1) begin
          lat_d       = 4'd0;
          dac_data_d  = proc_out;
          dac_start_d = 1'b1;
          state_d     = DAC_WAIT;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      DAC_WAIT: begin
        if (dac_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Set has priority over clear.
  always_comb begin
    if (drop)             overrun_d = 1'b1;
    else if (overrun_clr) overrun_d = 1'b0;
    else                  overrun_d = overrun_q;
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lat_q       <= '0;
      adc_start_q <= 1'b0;
      dac_start_q <= 1'b0;
      proc_in_q   <= '0;
      dac_data_q  <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      adc_start_q <= adc_start_d;
      dac_start_q <= dac_start_d;
      proc_in_q   <= proc_in_d;
      dac_data_q  <= dac_data_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef SEQ_OVERRUN_CNT_EN
  logic [7:0] ovr_cnt_q, ovr_cnt_d;

  // A drop coinciding with a clear restarts the count at one.
  always_comb begin
    ovr_cnt_d = ovr_cnt_q;
    if (drop) begin
      if (overrun_clr)              ovr_cnt_d = 8'd1;
      else if (ovr_cnt_q != 8'hFF)  ovr_cnt_d = ovr_cnt_q + 8'd1;
    end else if (overrun_clr) begin
      ovr_cnt_d = 8'd0;
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) ovr_cnt_q <= '0;
    else        ovr_cnt_q <= ovr_cnt_d;
  end

  assign overrun_cnt = ovr_cnt_q;
`endif

  assign adc_start = adc_start_q;
  assign dac_start = dac_start_q;
  assign proc_in   = proc_in_q;
  assign dac_data  = dac_data_q;
  assign busy      = (state_q != IDLE);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_sample_sequencer.sv
// Directed bench for sample_sequencer. Instance a uses PROC_LAT=1 and carries
// most of the sequence; instance b uses PROC_LAT=4 and stays disabled until
// the latency check near the end. Both use CLK_DIV=8. cyc counts rising edges
// since the most recent reset release; all checks happen 1 ns after an edge.
module tb_sample_sequencer;

  localparam int DW = 10;

  logic          sysclk;
  logic          rst_n;

  logic          en, adc_done, dac_done, overrun_clr;
  logic [DW-1:0] adc_data, proc_out;
  logic          adc_start, dac_start, busy, overrun;
  logic [DW-1:0] proc_in, dac_data;

  logic          en_b, adc_done_b, dac_done_b, overrun_clr_b;
  logic [DW-1:0] adc_data_b, proc_out_b;
  logic          adc_start_b, dac_start_b, busy_b, overrun_b;
  logic [DW-1:0] proc_in_b, dac_data_b;

`ifdef SEQ_OVERRUN_CNT_EN
  logic [7:0]    overrun_cnt, overrun_cnt_b;
`endif

  int vectors;
  int miscompares;
  int cyc;
  bit b_quiet;

  sample_sequencer #(.CLK_DIV(8), .PROC_LAT(1), .DW(DW)) dut_a (
    .sysclk      (sysclk),
    .rst_n       (rst_n),
    .en          (en),
    .adc_start   (adc_start),
    .adc_done    (adc_done),
    .adc_data    (adc_data),
    .proc_in     (proc_in),
    .proc_out    (proc_out),
    .dac_start   (dac_start),
    .dac_data    (dac_data),
    .dac_done    (dac_done),
    .busy        (busy),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
`ifdef SEQ_OVERRUN_CNT_EN
    ,
    .overrun_cnt (overrun_cnt)
`endif
  );

  sample_sequencer #(.CLK_DIV(8), .PROC_LAT(4), .DW(DW)) dut_b (
    .sysclk      (sysclk),
    .rst_n       (rst_n),
    .en          (en_b),
    .adc_start   (adc_start_b),
    .adc_done    (adc_done_b),
    .adc_data    (adc_data_b),
    .proc_in     (proc_in_b),
    .proc_out    (proc_out_b),
    .dac_start   (dac_start_b),
    .dac_data    (dac_data_b),
    .dac_done    (dac_done_b),
    .busy        (busy_b),
    .overrun     (overrun_b),
    .overrun_clr (overrun_clr_b)
`ifdef SEQ_OVERRUN_CNT_EN
    ,
    .overrun_cnt (overrun_cnt_b)
`endif
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Advance to cycle 'target'. With quiet set, instance a must not pulse
  // adc_start in any of the cycles passed through.
  task automatic adv_to(input int target, input bit quiet);
    while (cyc < target) begin
      @(posedge sysclk);
      #1;
      cyc++;
      if (quiet) chk("no_adc_start", {15'd0, adc_start}, 16'd0);
      if (b_quiet) begin
        chk("b_disabled_start", {15'd0, adc_start_b}, 16'd0);
        chk("b_disabled_busy",  {15'd0, busy_b},      16'd0);
      end
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0; cyc = 0; b_quiet = 1'b1;
    rst_n = 1'b0;
    en = 1'b1; adc_done = 1'b0; adc_data = '0; proc_out = 10'h3FF;
    dac_done = 1'b0; overrun_clr = 1'b0;
    en_b = 1'b0; adc_done_b = 1'b0; adc_data_b = '0; proc_out_b = 10'h1C3;
    dac_done_b = 1'b0; overrun_clr_b = 1'b0;

    // Reset state
    adv_to(2, 1'b0);
    chk("rst_adc_start", {15'd0, adc_start}, 16'd0);
    chk("rst_dac_start", {15'd0, dac_start}, 16'd0);
    chk("rst_proc_in",   {6'd0, proc_in},    16'd0);
    chk("rst_dac_data",  {6'd0, dac_data},   16'd0);
    chk("rst_busy",      {15'd0, busy},      16'd0);
    chk("rst_overrun",   {15'd0, overrun},   16'd0);
    rst_n = 1'b1;
    cyc = 0;

    // Basic sample, PROC_LAT=1
    adv_to(7, 1'b1);
    adv_to(8, 1'b0);
    chk("first_adc_start", {15'd0, adc_start}, 16'd1);
    chk("busy_adc_wait",   {15'd0, busy},      16'd1);
    adv_to(9, 1'b0);
    chk("adc_start_pulse", {15'd0, adc_start}, 16'd0);
    adv_to(11, 1'b1);
    adc_done = 1'b1; adc_data = 10'h2A5;
    adv_to(12, 1'b1);
    adc_done = 1'b0; adc_data = '0;
    chk("proc_in_capture", {6'd0, proc_in},    16'h02A5);
    chk("dac_start_early", {15'd0, dac_start}, 16'd0);
    adv_to(13, 1'b1);
    chk("dac_start_lat1",  {15'd0, dac_start}, 16'd1);
    chk("dac_data_lat1",   {6'd0, dac_data},   16'h03FF);
    adv_to(14, 1'b1);
    chk("dac_start_pulse", {15'd0, dac_start}, 16'd0);
    dac_done = 1'b1;
    adv_to(15, 1'b1);
    dac_done = 1'b0;
    chk("idle_after_dac",  {15'd0, busy},      16'd0);
    chk("no_overrun_yet",  {15'd0, overrun},   16'd0);
    adv_to(16, 1'b0);
    chk("second_adc_start", {15'd0, adc_start}, 16'd1);

    // DAC withholds dac_done for 12 cycles
    adv_to(19, 1'b1);
    adc_done = 1'b1; adc_data = 10'h155; proc_out = 10'h0AA;
    adv_to(20, 1'b1);
    adc_done = 1'b0; adc_data = '0;
    chk("proc_in_s2", {6'd0, proc_in}, 16'h0155);
    adv_to(21, 1'b1);
    chk("dac_start_s2", {15'd0, dac_start}, 16'd1);
    chk("dac_data_s2",  {6'd0, dac_data},   16'h00AA);
    adv_to(23, 1'b1);
    chk("overrun_before_tick", {15'd0, overrun}, 16'd0);
    adv_to(24, 1'b1);
    chk("overrun_on_tick", {15'd0, overrun}, 16'd1);
    chk("busy_in_dac_wait", {15'd0, busy},   16'd1);
    adv_to(25, 1'b1);
    adc_done = 1'b1; adc_data = 10'h3C3;
    adv_to(26, 1'b1);
    adc_done = 1'b0; adc_data = '0;
    chk("stray_adc_done_ignored", {6'd0, proc_in}, 16'h0155);
    adv_to(33, 1'b1);
    dac_done = 1'b1;
    adv_to(34, 1'b1);
    dac_done = 1'b0;
    chk("idle_after_late_dac", {15'd0, busy},   16'd0);
    chk("dac_data_held",       {6'd0, dac_data}, 16'h00AA);
    adv_to(39, 1'b1);
    adv_to(40, 1'b0);
    chk("adc_start_after_late_dac", {15'd0, adc_start}, 16'd1);

    // overrun_clr in an idle cycle, then coincident with a dropped tick
    adv_to(43, 1'b1);
    adc_done = 1'b1; adc_data = 10'h0F0;
    adv_to(44, 1'b1);
    adc_done = 1'b0;
    adv_to(45, 1'b1);
    chk("dac_start_s3", {15'd0, dac_start}, 16'd1);
    adv_to(46, 1'b1);
    dac_done = 1'b1;
    adv_to(47, 1'b1);
    dac_done = 1'b0;
    chk("overrun_sticky", {15'd0, overrun}, 16'd1);
    overrun_clr = 1'b1;
    adv_to(48, 1'b0);
    overrun_clr = 1'b0;
    chk("overrun_cleared", {15'd0, overrun},   16'd0);
    chk("adc_start_s4",    {15'd0, adc_start}, 16'd1);
    adv_to(55, 1'b1);
    overrun_clr = 1'b1;
    adv_to(56, 1'b1);
    overrun_clr = 1'b0;
    chk("overrun_set_wins", {15'd0, overrun}, 16'd1);
    adc_done = 1'b1; adc_data = 10'h111;
    adv_to(57, 1'b1);
    adc_done = 1'b0;
    chk("proc_in_s4", {6'd0, proc_in}, 16'h0111);
    adv_to(58, 1'b1);
    chk("dac_start_s4", {15'd0, dac_start}, 16'd1);
    adv_to(59, 1'b1);
    dac_done = 1'b1;
    adv_to(60, 1'b1);
    dac_done = 1'b0;
    chk("idle_s4", {15'd0, busy}, 16'd0);

    // en drops mid-ADC_WAIT: sample completes, nothing new starts
    adv_to(64, 1'b0);
    chk("adc_start_s5", {15'd0, adc_start}, 16'd1);
    adv_to(65, 1'b1);
    en = 1'b0;
    adv_to(67, 1'b1);
    adc_done = 1'b1; adc_data = 10'h2AA;
    adv_to(68, 1'b1);
    adc_done = 1'b0;
    chk("proc_in_en_low", {6'd0, proc_in}, 16'h02AA);
    adv_to(69, 1'b1);
    chk("dac_start_en_low", {15'd0, dac_start}, 16'd1);
    adv_to(70, 1'b1);
    dac_done = 1'b1;
    adv_to(71, 1'b1);
    dac_done = 1'b0;
    adv_to(96, 1'b1);
    chk("busy_en_low", {15'd0, busy}, 16'd0);

    // dac_done coincident with a tick in DAC_WAIT
    en = 1'b1; overrun_clr = 1'b1; proc_out = 10'h3A5;
    adv_to(97, 1'b1);
    overrun_clr = 1'b0;
    chk("overrun_clr_idle2", {15'd0, overrun}, 16'd0);
    adv_to(103, 1'b1);
    adv_to(104, 1'b0);
    chk("adc_start_s6", {15'd0, adc_start}, 16'd1);
    adv_to(105, 1'b1);
    adc_done = 1'b1; adc_data = 10'h0C3;
    adv_to(106, 1'b1);
    adc_done = 1'b0;
    adv_to(107, 1'b1);
    chk("dac_data_s6", {6'd0, dac_data}, 16'h03A5);
    adv_to(111, 1'b1);
    dac_done = 1'b1;
    adv_to(112, 1'b1);
    dac_done = 1'b0;
    chk("dac_done_tick_overrun", {15'd0, overrun}, 16'd1);
    chk("dac_done_tick_idle",    {15'd0, busy},    16'd0);
    adv_to(119, 1'b1);
    adv_to(120, 1'b0);
    chk("adc_start_next_tick", {15'd0, adc_start}, 16'd1);

    // Asynchronous reset while in PROC_WAIT
    adv_to(121, 1'b1);
    adc_done = 1'b1; adc_data = 10'h0C3;
    adv_to(122, 1'b1);
    adc_done = 1'b0;
    chk("proc_wait_busy", {15'd0, busy},    16'd1);
    chk("proc_in_s7",     {6'd0, proc_in},  16'h00C3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_proc_in",  {6'd0, proc_in},   16'd0);
    chk("async_rst_dac_data", {6'd0, dac_data},  16'd0);
    chk("async_rst_busy",     {15'd0, busy},     16'd0);
    chk("async_rst_overrun",  {15'd0, overrun},  16'd0);
    adv_to(cyc + 2, 1'b0);
    rst_n = 1'b1;
    cyc = 0;
    b_quiet = 1'b0;
    en_b = 1'b1;

    // Restart timing and PROC_LAT=4 on instance b
    adv_to(7, 1'b1);
    adv_to(8, 1'b0);
    chk("restart_adc_start",   {15'd0, adc_start},   16'd1);
    chk("b_adc_start",         {15'd0, adc_start_b}, 16'd1);
    adv_to(11, 1'b1);
    adc_done_b = 1'b1; adc_data_b = 10'h2A5;
    adv_to(12, 1'b1);
    adc_done_b = 1'b0;
    chk("b_proc_in", {6'd0, proc_in_b}, 16'h02A5);
    adv_to(15, 1'b1);
    chk("b_dac_start_early", {15'd0, dac_start_b}, 16'd0);
    adv_to(16, 1'b1);
    chk("b_dac_start_lat4", {15'd0, dac_start_b}, 16'd1);
    chk("b_dac_data_lat4",  {6'd0, dac_data_b},   16'h01C3);
    proc_out_b = 10'h000;
    adv_to(17, 1'b1);
    chk("b_dac_start_pulse", {15'd0, dac_start_b}, 16'd0);
    chk("b_dac_data_held",   {6'd0, dac_data_b},   16'h01C3);
    dac_done_b = 1'b1;
    adv_to(18, 1'b1);
    dac_done_b = 1'b0; en_b = 1'b0;
    chk("b_idle", {15'd0, busy_b}, 16'd0);

    // Instance a is stuck in ADC_WAIT: every tick from 15 on is dropped
    adv_to(2040, 1'b1);
    chk("many_overrun_flag", {15'd0, overrun}, 16'd1);
`ifdef SEQ_OVERRUN_CNT_EN
    chk("overrun_cnt_254", {8'd0, overrun_cnt}, 16'd254);
`endif
    adv_to(2416, 1'b1);
`ifdef SEQ_OVERRUN_CNT_EN
    chk("overrun_cnt_sat", {8'd0, overrun_cnt}, 16'd255);
`endif
    adv_to(2423, 1'b1);
    overrun_clr = 1'b1;
    adv_to(2424, 1'b1);
    chk("clr_with_tick_flag", {15'd0, overrun}, 16'd1);
`ifdef SEQ_OVERRUN_CNT_EN
    chk("clr_with_tick_cnt", {8'd0, overrun_cnt}, 16'd1);
`endif
    adv_to(2425, 1'b1);
    overrun_clr = 1'b0;
    chk("clr_no_tick_flag", {15'd0, overrun}, 16'd0);
`ifdef SEQ_OVERRUN_CNT_EN
    chk("clr_no_tick_cnt", {8'd0, overrun_cnt}, 16'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sample_sequencer.md
Name: sample_sequencer

Overview:
Sequencer for the sampled audio path ADC -> processor -> DAC. Generates the sample-rate tick from sysclk and issues the ADC conversion start. Captures the ADC word into the processor input, waits out the processor's register latency, then loads the result into the DAC. Flags sample overruns when a tick arrives before the previous sample has fully completed.

Parameters:
CLK_DIV, 5000, sysclk cycles per sample period (50 MHz / 5000 = 10 kHz); legal range >= 4.
PROC_LAT, 1, sysclk cycles from proc_in change to valid proc_out; legal range 1..15.
DW, 10, sample data width.

Ports:
sysclk  in  1  system clock, all logic on posedge
rst_n  in  1  asynchronous active-low reset
en  in  1  sampling enable; when low, ticks are ignored
adc_start  out  1  one-cycle pulse to start an ADC conversion
adc_done  in  1  one-cycle pulse; adc_data valid in the same cycle
adc_data  in  DW  ADC result
proc_in  out  DW  registered sample presented to the processor datapath
proc_out  in  DW  processor result
dac_start  out  1  one-cycle pulse; dac_data valid from this cycle on
dac_data  out  DW  registered DAC word, held until the next load
dac_done  in  1  one-cycle pulse, DAC transfer complete
busy  out  1  high whenever state != IDLE
overrun  out  1  sticky overrun flag
overrun_clr  in  1  synchronous clear of overrun

Behaviour:
- Reset (rst_n low, asynchronous): tick counter = 0, state = IDLE, all pulses = 0, proc_in = 0, dac_data = 0, overrun = 0, busy = 0.
- Tick counter: free-runs 0..CLK_DIV-1 and wraps regardless of en or state. tick = (count == CLK_DIV-1), i.e. one tick every CLK_DIV cycles, first tick CLK_DIV cycles after reset release.
- FSM states: IDLE, ADC_WAIT, PROC_WAIT, DAC_WAIT.
  - IDLE: on tick with en=1, assert adc_start for 1 cycle and go to ADC_WAIT.
  - ADC_WAIT: on adc_done, register adc_data into proc_in, load latency counter = PROC_LAT, go to PROC_WAIT.
  - PROC_WAIT: decrement each cycle. When it reaches 0, register proc_out into dac_data, pulse dac_start for 1 cycle, go to DAC_WAIT.
  - DAC_WAIT: on dac_done, go to IDLE.
- Latency: adc_start is asserted the cycle after the tick cycle. proc_in updates the cycle after adc_done. dac_start/dac_data update exactly PROC_LAT+1 cycles after adc_done.
- Boundary conditions:
  - tick with en=1 while state != IDLE: overrun <= 1; the tick is dropped; the in-flight sample is not disturbed.
  - tick and overrun_clr in the same cycle while busy: set wins, overrun = 1.
  - adc_done outside ADC_WAIT, or dac_done outside DAC_WAIT: ignored, no state change.
  - dac_done in the same cycle as a tick while in DAC_WAIT: counts as an overrun; return to IDLE; no new adc_start until the next tick.
  - en falling mid-transaction: the current sample completes normally. en only gates starting a new sample.
- Outputs proc_in and dac_data are never cleared except by reset. The DAC holds its last value between samples.

Optional Feature:
Macro SEQ_OVERRUN_CNT_EN.
- Defined: adds output overrun_cnt[7:0], a saturating count of dropped ticks (stops at 255). overrun_clr clears it to 0 together with overrun; an increment in the same cycle wins, leaving the count at 1.
- Undefined: port and counter absent; only the sticky overrun flag exists.

Decomposition:
- Shared package sample_pkg holds:
  - state encoding enum seq_state_t (IDLE=0, ADC_WAIT=1, PROC_WAIT=2, DAC_WAIT=3);
  - SAMPLE_DW = 10;
  - default CLK_DIV_10K = 5000.
- One sub-module is natural: sample_tick_gen (parameter CLK_DIV; ports sysclk, rst_n, tick), the free-running divider. It is reused for other sample-rate blocks.

Test Plan:
1. Reset release, CLK_DIV=8, PROC_LAT=1, en=1, ADC model answers adc_done 3 cycles after adc_start with 10'h2A5 -> adc_start at cycle 8, proc_in = 10'h2A5 the cycle after adc_done; with proc_out = 10'h3FF, dac_start and dac_data = 10'h3FF 2 cycles after adc_done.
2. PROC_LAT=4, same stimulus -> dac_start exactly 5 cycles after adc_done; dac_data holds the proc_out value sampled in that cycle.
3. DAC model withholds dac_done for 12 cycles (CLK_DIV=8) -> overrun = 1 on the second tick; no second adc_start until after dac_done and the following tick.
4. overrun set, then overrun_clr pulsed in an idle cycle -> overrun = 0 next cycle. overrun_clr coincident with an overrunning tick -> overrun stays 1.
5. en=0 from reset for 3 periods -> no adc_start, busy = 0. Drop en mid-ADC_WAIT -> sample completes (dac_start seen), then no further adc_start.
6. Assert rst_n low asynchronously in PROC_WAIT -> outputs zero immediately without a clock edge. After release, the first adc_start comes CLK_DIV cycles later. With SEQ_OVERRUN_CNT_EN, 300 forced overruns -> overrun_cnt = 255.
